// File: rtl/shiftreg_generator_if.sv
// Bundles the word sources, select strobes, latched words and serial output
// of the shift-register generator; master drives selects/words, slave serves them.
interface shiftreg_generator_if #(
   parameter int SIZESRSTAT = 88,
   parameter int SIZESRDYN  = 16
);
   logic                  SELDYN;
   logic                  SELSTAT;
   logic [SIZESRDYN-1:0]  DYNREG;
   logic [SIZESRSTAT-1:0] STATREG;
   logic [SIZESRDYN-1:0]  DYNLATCH;
   logic [SIZESRSTAT-1:0] STATLATCH;
   logic                  signal_out;

   modport master (
      output SELDYN, SELSTAT, DYNREG, STATREG,
      input  DYNLATCH, STATLATCH, signal_out
   );

   modport slave (
      input  SELDYN, SELSTAT, DYNREG, STATREG,
      output DYNLATCH, STATLATCH, signal_out
   );
endinterface

// File: rtl/shiftreg_generator.sv
// Serial generator: a rising select edge latches the dynamic or static word
// and shifts it out MSB-first on signal_out, one bit per clock.
module shiftreg_generator #(
   parameter int SIZESRSTAT = 88,
   parameter int SIZESRDYN  = 16
) (
   input  logic CLK,
   input  logic RST_N,
   shiftreg_generator_if.slave bus
);
   localparam int CNT_W = $clog2(SIZESRSTAT + 1);
   localparam logic [CNT_W-1:0] DYN_LEN  = CNT_W'(SIZESRDYN);
   localparam logic [CNT_W-1:0] STAT_LEN = CNT_W'(SIZESRSTAT);

   typedef enum logic [1:0] {IDLE, SHIFT_DYN, SHIFT_STAT} state_t;

   state_t                state_q, state_d;
   logic                  seldyn_hist_q, seldyn_hist_d;
   logic                  selstat_hist_q, selstat_hist_d;
   logic [SIZESRSTAT-1:0] sr_q, sr_d;
   logic [SIZESRSTAT-1:0] statlatch_q, statlatch_d;
   logic [SIZESRDYN-1:0]  dynlatch_q, dynlatch_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  out_q, out_d;
   logic                  dyn_start, stat_start;
   logic [CNT_W-1:0]      frame_len;
   logic [SIZESRSTAT-1:0] dyn_aligned;

   assign dyn_start   = bus.SELDYN & ~seldyn_hist_q;
   assign stat_start  = bus.SELSTAT & ~selstat_hist_q;
   assign frame_len   = (state_q == SHIFT_DYN) ? DYN_LEN : STAT_LEN;
   // Dynamic word sits in the top bits so both frames shift from the same MSB.
   assign dyn_aligned = {bus.DYNREG, {(SIZESRSTAT-SIZESRDYN){1'b0}}};

   always_comb begin
      state_d        = state_q;
      sr_d           = sr_q;
      statlatch_d    = statlatch_q;
      dynlatch_d     = dynlatch_q;
      cnt_d          = cnt_q;
      out_d          = out_q;
      seldyn_hist_d  = bus.SELDYN;
      selstat_hist_d = bus.SELSTAT;
      case (state_q)
         IDLE: begin
            out_d = 1'b0;
            if (dyn_start) begin
               dynlatch_d = bus.DYNREG;
               sr_d       = dyn_aligned << 1;
               out_d      = bus.DYNREG[SIZESRDYN-1];
               cnt_d      = CNT_W'(1);
               state_d    = SHIFT_DYN;
            end else if (stat_start) begin
               statlatch_d = bus.STATREG;
               sr_d        = bus.STATREG << 1;
               out_d       = bus.STATREG[SIZESRSTAT-1];
               cnt_d       = CNT_W'(1);
               state_d     = SHIFT_STAT;
            end
         end
         SHIFT_DYN, SHIFT_STAT: begin
            if (cnt_q == frame_len) begin
               out_d   = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               out_d = sr_q[SIZESRSTAT-1];
               sr_d  = sr_q << 1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST_N) begin
         state_q        <= IDLE;
         seldyn_hist_q  <= 1'b0;
         selstat_hist_q <= 1'b0;
         sr_q           <= '0;
         statlatch_q    <= '0;
         dynlatch_q     <= '0;
         cnt_q          <= '0;
         out_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         seldyn_hist_q  <= seldyn_hist_d;
         selstat_hist_q <= selstat_hist_d;
         sr_q           <= sr_d;
         statlatch_q    <= statlatch_d;
         dynlatch_q     <= dynlatch_d;
         cnt_q          <= cnt_d;
         out_q          <= out_d;
      end
   end

   assign bus.DYNLATCH   = dynlatch_q;
   assign bus.STATLATCH  = statlatch_q;
   assign bus.signal_out = out_q;
endmodule

// File: tb/tb_shiftreg_generator.sv
// Scoreboard bench: a frame-level model predicts each cycle's serial bit and
// latch contents; a monitor compares them against the generator every cycle.
module tb_shiftreg_generator;
   localparam int SW = 88;
   localparam int DW = 16;

   logic CLK = 1'b0;
   logic RST_N;
   always #5 CLK = ~CLK;

   shiftreg_generator_if #(.SIZESRSTAT(SW), .SIZESRDYN(DW)) bus ();

   shiftreg_generator #(.SIZESRSTAT(SW), .SIZESRDYN(DW)) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .bus  (bus)
   );

   typedef struct {
      logic          out;
      logic [DW-1:0] dl;
      logic [SW-1:0] sl;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: a frame is a queue of bits; a new request is honoured
   // only when no frame bits remain and the previous cycle carried no frame bit.
   logic          m_hist_dyn = 1'b0, m_hist_stat = 1'b0, m_last = 1'b0, m_out;
   logic [DW-1:0] m_dl = '0;
   logic [SW-1:0] m_sl = '0;
   logic          stream[$];

   always @(posedge CLK) begin
      exp_t e;
      logic rd, rs;
      if (RST_N) begin
         stream.delete();
         m_dl = '0; m_sl = '0; m_last = 1'b0; m_out = 1'b0;
         m_hist_dyn = 1'b0; m_hist_stat = 1'b0;
      end else begin
         rd = bus.SELDYN && !m_hist_dyn;
         rs = bus.SELSTAT && !m_hist_stat;
         if (stream.size() == 0 && !m_last) begin
            if (rd) begin
               m_dl = bus.DYNREG;
               for (int i = DW - 1; i >= 0; i--) stream.push_back(bus.DYNREG[i]);
            end else if (rs) begin
               m_sl = bus.STATREG;
               for (int i = SW - 1; i >= 0; i--) stream.push_back(bus.STATREG[i]);
            end
         end
         if (stream.size() != 0) begin
            m_out = stream.pop_front();
            m_last = 1'b1;
         end else begin
            m_out = 1'b0;
            m_last = 1'b0;
         end
         m_hist_dyn  = bus.SELDYN;
         m_hist_stat = bus.SELSTAT;
      end
      e.out = m_out; e.dl = m_dl; e.sl = m_sl;
      exp_q.push_back(e);
   end

   always @(posedge CLK) begin
      exp_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         if (bus.signal_out !== e.out || bus.DYNLATCH !== e.dl || bus.STATLATCH !== e.sl) begin
            bad++;
            $display("FAIL cycle t=%0t out=%b/%b dynlatch=%h/%h statlatch=%h/%h (got/expected)",
                     $time, bus.signal_out, e.out, bus.DYNLATCH, e.dl, bus.STATLATCH, e.sl);
         end
      end
   end

   task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic capture(input int n, output logic [SW-1:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         v = {v[SW-2:0], bus.signal_out};
      end
   endtask

   localparam logic [SW-1:0] STAT_A = 88'h123456789ABCDEF1234567;
   localparam logic [SW-1:0] STAT_B = 88'hA1B2C3D4E5F67890ABCDE1;

   initial begin
      logic [SW-1:0] v;
      RST_N = 1'b1;
      bus.SELDYN = 1'b1; bus.SELSTAT = 1'b0;
      bus.DYNREG = 16'h1357; bus.STATREG = '0;
      @(posedge CLK); @(posedge CLK); #1;
      check("rst_dynlatch", SW'(bus.DYNLATCH), '0);
      check("rst_statlatch", bus.STATLATCH, '0);
      check("rst_out", SW'(bus.signal_out), '0);

      @(negedge CLK); RST_N = 1'b0;
      capture(DW, v);
      check("release_frame", SW'(v[DW-1:0]), SW'(16'h1357));
      @(posedge CLK); #1;
      check("release_end", SW'(bus.signal_out), '0);

      @(negedge CLK); bus.SELDYN = 1'b0; bus.DYNREG = 16'hABCD;
      repeat (2) @(negedge CLK);
      bus.SELDYN = 1'b1;
      capture(DW, v);
      check("dyn_abcd_bits", SW'(v[DW-1:0]), SW'(16'hABCD));
      check("dyn_abcd_latch", SW'(bus.DYNLATCH), SW'(16'hABCD));
      @(posedge CLK); #1;
      check("dyn_abcd_end", SW'(bus.signal_out), '0);

      @(negedge CLK); bus.SELDYN = 1'b0; bus.STATREG = STAT_A;
      @(negedge CLK); bus.SELSTAT = 1'b1;
      v = '0;
      for (int i = 0; i < SW; i++) begin
         @(posedge CLK); #1;
         v = {v[SW-2:0], bus.signal_out};
         if (i == 1) check("stat_latch", bus.STATLATCH, STAT_A);
         if (i == 5) bus.SELSTAT = 1'b0;
         if (i == 20) begin
            bus.DYNREG = 16'h5678; bus.STATREG = STAT_B; bus.SELDYN = 1'b1;
         end
         if (i == 30) bus.SELDYN = 1'b0;
         if (i == 40) bus.SELDYN = 1'b1;
         if (i == 50) bus.SELDYN = 1'b0;
      end
      check("stat_first8", SW'(v[SW-1:SW-8]), SW'(8'b0001_0010));
      check("stat_last8", SW'(v[7:0]), SW'(8'b0110_0111));
      check("stat_bits", v, STAT_A);
      check("midframe_dynlatch", SW'(bus.DYNLATCH), SW'(16'hABCD));
      @(posedge CLK); #1;
      check("stat_end", SW'(bus.signal_out), '0);

      @(negedge CLK); bus.SELDYN = 1'b1;
      capture(DW, v);
      check("dyn_5678_bits", SW'(v[DW-1:0]), SW'(16'h5678));

      @(negedge CLK); bus.SELDYN = 1'b0; bus.DYNREG = 16'h9E3C;
      repeat (2) @(negedge CLK);
      bus.SELDYN = 1'b1; bus.SELSTAT = 1'b1;
      capture(DW, v);
      check("simul_bits", SW'(v[DW-1:0]), SW'(16'h9E3C));
      check("simul_statlatch", bus.STATLATCH, STAT_A);
      capture(20, v);
      check("simul_no_static", SW'(v[19:0]), '0);

      @(negedge CLK); bus.SELDYN = 1'b0; bus.SELSTAT = 1'b0; bus.DYNREG = 16'hFFFF;
      repeat (2) @(negedge CLK);
      bus.SELDYN = 1'b1;
      capture(6, v);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      check("midrst_out", SW'(bus.signal_out), '0);
      check("midrst_dynlatch", SW'(bus.DYNLATCH), '0);
      check("midrst_statlatch", bus.STATLATCH, '0);
      @(negedge CLK); bus.SELDYN = 1'b0; RST_N = 1'b0;
      capture(20, v);
      check("midrst_no_residue", SW'(v[19:0]), '0);

      repeat (3000) begin
         @(negedge CLK);
         if ($urandom_range(0, 7) == 0) bus.SELDYN = ~bus.SELDYN;
         if ($urandom_range(0, 7) == 0) bus.SELSTAT = ~bus.SELSTAT;
         bus.DYNREG  = 16'($urandom);
         bus.STATREG = SW'({$urandom, $urandom, $urandom});
         RST_N = ($urandom_range(0, 199) == 0);
      end
      @(negedge CLK); RST_N = 1'b0;
      repeat (5) @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/shiftreg_generator.md
Name: shiftreg_generator

Overview:
- Serial bit-stream generator with two parallel-load sources: a short dynamic word (DYNREG) and a long static word (STATREG).
- A rising edge on a select input captures the chosen word into its latch register, then shifts it out MSB-first on signal_out, one bit per clock.
- Sits between the configuration/control logic that writes the words and the serial output pad/line.

Parameters:
- SIZESRSTAT, 88, bit width of the static word, STATREG/STATLATCH, and the static shift length.
- SIZESRDYN, 16, bit width of the dynamic word, DYNREG/DYNLATCH, and the dynamic shift length.

Ports:
- CLK  input  1  single system clock; all logic on the rising edge.
- RST_N  input  1  synchronous reset, active-high: reset is applied at a CLK rising edge when RST_N=1.
- SELDYN  input  1  level; a 0->1 transition requests a dynamic-word transmission.
- SELSTAT  input  1  level; a 0->1 transition requests a static-word transmission.
- DYNREG  input  SIZESRDYN  dynamic word source.
- STATREG  input  SIZESRSTAT  static word source.
- DYNLATCH  output  SIZESRDYN  registered copy of DYNREG captured at the last dynamic start.
- STATLATCH  output  SIZESRSTAT  registered copy of STATREG captured at the last static start.
- signal_out  output  1  registered serial data, MSB first; 0 when idle.

Behaviour:
- Reset (RST_N=1 at an edge): DYNLATCH=0, STATLATCH=0, signal_out=0, internal shift register=0, bit counter=0, select-history flops=0, state=IDLE. Reset overrides everything, including a transmission in progress, which is aborted.
- Edge detection: registered copies seldyn_d/selstat_d. Start condition is dyn_start = SELDYN & ~seldyn_d (same form for static). History flops update every non-reset cycle, in all states.
- Because history flops clear on reset, a select held high through reset triggers one start on the first non-reset edge.
- State machine has three states: IDLE, SHIFT_DYN, SHIFT_STAT.
- IDLE + dyn_start at edge N:
  - DYNLATCH<=DYNREG; shift register<=DYNREG; signal_out<=DYNREG[SIZESRDYN-1]; counter<=1; state<=SHIFT_DYN.
- IDLE + stat_start (no dyn_start): same sequence using STATREG/STATLATCH, state<=SHIFT_STAT.
- Simultaneous dyn_start and stat_start in IDLE: dynamic wins; the static request is dropped (not queued).
- SHIFT_x: each edge, signal_out<=next lower bit and counter increments.
  - Bit k (k=0 is MSB) is valid on signal_out from edge N+k to edge N+k+1.
  - At edge N+SIZE (SIZE = word width), signal_out<=0 and state<=IDLE.
  - A frame therefore occupies exactly SIZE cycles.
- Start edges arriving while in SHIFT_DYN or SHIFT_STAT are ignored (not queued). A new start is accepted in the IDLE cycle following the end of a frame, provided a fresh 0->1 edge occurs.
- Latch outputs change only at a start (or reset); input changes during a frame do not affect the shifted data or the latches.
- Falling edges of the selects have no effect.
- signal_out is never X after reset. Zero-latency path from CLK edge only (fully registered output).

Test Plan:
- Reset: hold RST_N=1 for 2 edges with SELDYN=1 -> DYNLATCH=0, STATLATCH=0, signal_out=0. Release -> dynamic start on the first edge.
- Dynamic frame: DYNREG=16'hABCD, SELDYN 0->1 -> DYNLATCH=16'hABCD; signal_out over 16 cycles = 1010 1011 1100 1101; then 0 and IDLE.
- Static frame: STATREG=88'h123456789ABCDEF1234567, SELSTAT 0->1 -> STATLATCH=that value; first 8 serial bits 0001 0010, last 8 bits 0110 0111, 88 cycles total; then 0.
- Input change mid-frame: during a static frame change DYNREG=16'h5678 and STATREG=88'hA1B2C3D4E5F67890ABCDE1, toggle SELDYN -> frame completes with original data, no dynamic frame starts, and DYNLATCH is unchanged. A later SELDYN edge in IDLE transmits 0101 0110 0111 1000.
- Simultaneous starts: SELDYN and SELSTAT rise on the same edge -> dynamic frame only; STATLATCH unchanged.
- Reset mid-frame: assert RST_N at bit 5 of a dynamic frame -> next edge signal_out=0, latches=0, IDLE; no residual bits after release.
